// File: rtl/gpu_pkg.sv
// Shared core-level encodings: core phase codes driven by the scheduler and
// the fetcher's reported state codes. Scheduler and PC logic import these too.
package gpu_pkg;

  // core phase, as broadcast by the scheduler
  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  // fetcher state as reported back to the scheduler
  localparam logic [2:0] FETCHER_IDLE     = 3'b000;
  localparam logic [2:0] FETCHER_FETCHING = 3'b001;
  localparam logic [2:0] FETCHER_FETCHED  = 3'b010;

  typedef enum logic [2:0] {
    FS_IDLE     = FETCHER_IDLE,
    FS_FETCHING = FETCHER_FETCHING,
    FS_FETCHED  = FETCHER_FETCHED
  } fetcher_state_e;

endpackage

// File: rtl/fetcher.sv
// Program-memory instruction fetcher for one compute core.
// Issues one valid/ready read per FETCH phase and holds the returned word
// for the decoder until the next fetch completes.
// Optional feature macro FETCHER_REUSE_EN: remember the address of the last
// completed fetch and skip the memory read when the same PC is fetched again.
module fetcher
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

  fetcher_state_e state;

`ifdef FETCHER_REUSE_EN
  logic                             tag_vld;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] tag_addr;
  logic                             tag_hit;

  // current PC matches the last completed fetch, so the held word is reusable
  assign tag_hit = tag_vld && (current_pc == tag_addr);
`endif

  assign fetcher_state = state;

  // fetch FSM: request issue, handshake completion and decoder release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= FS_IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
`ifdef FETCHER_REUSE_EN
      tag_vld          <= 1'b0;
      tag_addr         <= '0;
`endif
    end else begin
      case (state)
        FS_IDLE: begin
          // enable only gates the start of a fetch, never an in-flight one
          if (enable && core_state == CORE_FETCH) begin
`ifdef FETCHER_REUSE_EN
            if (tag_hit) begin
              state <= FS_FETCHED;
            end else begin
              mem_read_address <= current_pc;
              mem_read_valid   <= 1'b1;
              state            <= FS_FETCHING;
            end
`else
            mem_read_address <= current_pc;
            mem_read_valid   <= 1'b1;
            state            <= FS_FETCHING;
`endif
          end
        end
        FS_FETCHING: begin
          // address and valid hold until the controller answers; PC and
          // core_state changes are deliberately ignored here
          if (mem_read_ready) begin
            instruction    <= mem_read_data;
            mem_read_valid <= 1'b0;
            state          <= FS_FETCHED;
`ifdef FETCHER_REUSE_EN
            tag_vld        <= 1'b1;
            tag_addr       <= mem_read_address;
`endif
          end
        end
        FS_FETCHED: begin
          if (core_state == CORE_DECODE) state <= FS_IDLE;
        end
        default: state <= FS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetcher.sv
// Scoreboard bench for fetcher: the driver pushes expected request addresses
// and fetched words computed from a random program image; a free-running
// monitor pops and compares whenever the DUT raises a request or reaches
// FETCHED, and checks handshake stability in between.
module tb_fetcher;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [2:0]    core_state = 3'b000;
  logic [AW-1:0] current_pc = '0;
  logic          mem_read_valid;
  logic [AW-1:0] mem_read_address;
  logic          mem_read_ready = 1'b0;
  logic [DW-1:0] mem_read_data = '0;
  logic [2:0]    fetcher_state;
  logic [DW-1:0] instruction;

  fetcher #(.PROGRAM_MEM_ADDR_BITS(AW), .PROGRAM_MEM_DATA_BITS(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .current_pc(current_pc), .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address), .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data), .fetcher_state(fetcher_state),
    .instruction(instruction)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mem [256];
  logic [AW-1:0] q_addr [$];
  logic [DW-1:0] q_instr [$];

  // reference state: what the core has most recently been handed
  bit            last_vld = 0;
  logic [AW-1:0] last_pc = '0;
  logic [DW-1:0] last_instr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: sampled 1 time unit after each rising edge
  initial begin
    logic          p_vld;
    logic [2:0]    p_st;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_instr;
    p_vld = 0; p_st = 3'b000; p_addr = '0; p_instr = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        p_vld = 0; p_st = 3'b000;
      end else begin
        if (mem_read_valid && !p_vld) begin
          if (q_addr.size() == 0) chk("unexpected_request", {24'd0, mem_read_address}, 32'hFFFF_FFFF);
          else chk("request_addr", {24'd0, mem_read_address}, {24'd0, q_addr.pop_front()});
        end
        if (mem_read_valid && p_vld) chk("addr_stable", {24'd0, mem_read_address}, {24'd0, p_addr});
        if (!mem_read_valid && p_vld) chk("valid_drop_only_on_done", {29'd0, fetcher_state}, 32'd2);
        if (fetcher_state == 3'b010 && p_st != 3'b010) begin
          if (q_instr.size() == 0) chk("unexpected_fetched", {16'd0, instruction}, 32'hFFFF_FFFF);
          else chk("instruction", {16'd0, instruction}, {16'd0, q_instr.pop_front()});
        end
        if (fetcher_state == 3'b010 && p_st == 3'b010) chk("instr_hold", {16'd0, instruction}, {16'd0, p_instr});
        p_vld = mem_read_valid; p_st = fetcher_state;
        p_addr = mem_read_address; p_instr = instruction;
      end
    end
  end

  // one complete fetch with a memory that answers after `delay` cycles
  task automatic do_fetch(input logic [AW-1:0] pc, input int delay,
                          input bit drop_en, input bit pc_change, input bit odd_phase);
    bit hit;
    int cyc, waited, exp_lat;
    hit = 0;
`ifdef FETCHER_REUSE_EN
    hit = last_vld && (last_pc == pc);
`endif
    @(negedge clk);
    current_pc = pc; core_state = 3'b001; enable = 1'b1; mem_read_ready = 1'b0;
    if (hit) q_instr.push_back(last_instr);
    else begin
      q_addr.push_back(pc);
      q_instr.push_back(mem[pc]);
      last_instr = mem[pc];
    end
    last_vld = 1; last_pc = pc;
    exp_lat = hit ? 1 : 2 + delay;
    cyc = 0; waited = 0;
    while (cyc < 60) begin
      @(negedge clk); cyc++;
      if (fetcher_state == 3'b010) break;
      if (drop_en)   enable = 1'b0;
      if (pc_change) current_pc = AW'($urandom);
      if (odd_phase) core_state = 3'b100;
      if (mem_read_valid && waited == delay) begin
        mem_read_ready = 1'b1; mem_read_data = mem[pc];
      end else begin
        mem_read_ready = 1'b0; mem_read_data = DW'($urandom);
        if (mem_read_valid) waited++;
      end
    end
    mem_read_ready = 1'b0;
    chk("fetch_latency", cyc, exp_lat);
    // spurious ready while FETCHED, then release via DECODE
    core_state = 3'b101; mem_read_ready = 1'b1; mem_read_data = 16'hBEEF;
    @(negedge clk);
    mem_read_ready = 1'b0;
    chk("fetched_holds", {29'd0, fetcher_state}, 32'd2);
    core_state = 3'b010;
    @(negedge clk);
    chk("decode_to_idle", {29'd0, fetcher_state}, 32'd0);
    // spurious ready while IDLE
    core_state = 3'b000; mem_read_ready = 1'b1; mem_read_data = 16'hBEEF;
    @(negedge clk);
    mem_read_ready = 1'b0;
    chk("idle_spurious_state", {29'd0, fetcher_state}, 32'd0);
    chk("idle_spurious_instr", {16'd0, instruction}, {16'd0, last_instr});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    mem[8'h03] = 16'h1234;
    mem[8'h10] = 16'hA5A5;

    // reset state
    #1;
    chk("rst_valid", {31'd0, mem_read_valid}, 32'd0);
    chk("rst_addr", {24'd0, mem_read_address}, 32'd0);
    chk("rst_state", {29'd0, fetcher_state}, 32'd0);
    chk("rst_instr", {16'd0, instruction}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // reset in the middle of a fetch
    @(negedge clk);
    current_pc = 8'h05; core_state = 3'b001; enable = 1'b1;
    q_addr.push_back(8'h05);
    @(negedge clk);
    chk("midfetch_valid_before", {31'd0, mem_read_valid}, 32'd1);
    chk("midfetch_addr_before", {24'd0, mem_read_address}, 32'h05);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, mem_read_valid}, 32'd0);
    chk("async_rst_addr", {24'd0, mem_read_address}, 32'd0);
    chk("async_rst_state", {29'd0, fetcher_state}, 32'd0);
    core_state = 3'b000;
    q_addr.delete(); q_instr.delete();
    last_vld = 0; last_instr = '0;
    @(negedge clk);
    reset = 1'b1;

    // enable low blocks the start of a fetch
    @(negedge clk);
    enable = 1'b0; core_state = 3'b001; current_pc = 8'h22;
    repeat (4) @(negedge clk);
    chk("enable_gate_state", {29'd0, fetcher_state}, 32'd0);
    chk("enable_gate_valid", {31'd0, mem_read_valid}, 32'd0);
    core_state = 3'b000;

    // directed: basic, back-pressure with PC change, enable drop, reuse
    do_fetch(8'h03, 3, 0, 0, 0);
    do_fetch(8'h03, 10, 0, 1, 0);
    do_fetch(8'h40, 0, 1, 0, 1);
    do_fetch(8'h10, 1, 0, 0, 0);
    do_fetch(8'h10, 2, 0, 0, 0);
    do_fetch(8'h11, 0, 0, 0, 0);

    // randomized traffic over a small PC window so repeats occur
    for (int k = 0; k < 40; k++)
      do_fetch(AW'($urandom_range(0, 5)), $urandom_range(0, 4),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));

    repeat (3) @(negedge clk);
    chk("addr_queue_drained", q_addr.size(), 0);
    chk("instr_queue_drained", q_instr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetcher.md
# fetcher

Program-memory reader for one compute core: takes the `current_pc` produced by the core's program counter logic, issues a read request to the program memory controller over a valid/ready handshake, and latches the returned instruction for the decoder. One instance per core; all threads of the core share the fetched instruction. Advances only in the FETCH phase of the core state machine and reports its own state back to the core scheduler.

## Interface

- `PROGRAM_MEM_ADDR_BITS`, 8, width of a program memory address / PC
- `PROGRAM_MEM_DATA_BITS`, 16, width of one instruction word

- `clk`  in  1  core clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `enable`  in  1  core active for current block; gates only the start of a new fetch
- `core_state`  in  3  core phase: IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111
- `current_pc`  in  PROGRAM_MEM_ADDR_BITS  address of instruction to fetch
- `mem_read_valid`  out  1  read request outstanding
- `mem_read_address`  out  PROGRAM_MEM_ADDR_BITS  request address, stable while valid
- `mem_read_ready`  in  1  memory controller returns data this cycle
- `mem_read_data`  in  PROGRAM_MEM_DATA_BITS  instruction word, sampled when ready
- `fetcher_state`  out  3  IDLE=000, FETCHING=001, FETCHED=010
- `instruction`  out  PROGRAM_MEM_DATA_BITS  last fetched instruction

## Operation

- States: IDLE, FETCHING, FETCHED; all outputs registered.
- IDLE: if `enable` and `core_state`==FETCH: `mem_read_address`<=`current_pc`, `mem_read_valid`<=1, go FETCHING. Otherwise hold.
- FETCHING: `mem_read_valid` and `mem_read_address` held constant. On edge with `mem_read_ready`=1: `instruction`<=`mem_read_data`, `mem_read_valid`<=0, go FETCHED. `current_pc` changes while FETCHING are ignored.
- FETCHED: `instruction` held. When `core_state`==DECODE go IDLE. Any other core_state: hold.
- `mem_read_ready` while not FETCHING: ignored, no state or data change.
- `enable` low in FETCHING or FETCHED: in-flight transaction completes normally; enable only blocks IDLE->FETCHING.
- `core_state` leaving FETCH during FETCHING: illegal from scheduler; fetcher still completes the handshake.
- Reset (any time, including mid-fetch): `fetcher_state`=IDLE, `mem_read_valid`=0, `mem_read_address`=0, `instruction`=0, immediately (async). Abandoned request is dropped; controller must not depend on completion.

## Timing

- Request issue: valid high 1 cycle after the edge where IDLE sees FETCH.
- Minimum latency FETCH seen -> FETCHED: 2 edges (ready high on first cycle valid is high).
- `instruction` valid from the cycle `fetcher_state`==FETCHED until next fetch completes.
- Exactly one request per fetch; valid never deasserts without a ready, except on reset.
- Reset release: first active edge after `reset` rises may start a fetch.

## Configuration

- `FETCHER_REUSE_EN` defined: a tag register (address + valid bit, invalid on reset) records the last completed fetch. In IDLE with FETCH, if tag valid and `current_pc`==tag, go straight to FETCHED next edge, no request, `instruction` unchanged. Tag updated on every completed fetch.
- Not defined: no tag; every FETCH issues a memory request. Port list identical in both builds.

## Structure

- Shared package `gpu_pkg`: core_state encodings (IDLE..DONE) and fetcher state encodings (IDLE/FETCHING/FETCHED) as localparams; the scheduler and PC logic use the same constants.
- Single module; no sub-module. Tag compare is inline under the macro.

## Test plan

- Reset mid-fetch: valid=1, addr=0x05, assert `reset`=0 -> valid=0, addr=0, state=IDLE same cycle, no edge needed.
- Basic fetch: pc=0x03, core_state=FETCH, ready high 3 cycles after valid with data=0x1234 -> instruction=0x1234, state FETCHED; core_state=DECODE -> IDLE next edge.
- Back-pressure: ready low 10 cycles, pc changed to 0x07 meanwhile -> addr stays 0x03, valid stays 1 throughout, single completion.
- Spurious ready: ready=1, data=0xBEEF while IDLE and FETCHED -> instruction and state unchanged.
- Enable gating: enable=0, core_state=FETCH -> no request; enable dropped during FETCHING -> fetch completes.
- `FETCHER_REUSE_EN`: fetch pc=0x10 (data 0xA5A5), return to IDLE, FETCH again pc=0x10 -> FETCHED in 1 edge, valid never asserted; pc=0x11 -> normal request.
